// File: rtl/obuf_bias_psum_mux.sv
// obuf_bias_psum_mux
// Routes accumulator row reads to the bias buffer or the output buffer,
// carries a {valid, sel, last} tag alongside each read for the buffers'
// fixed latency, and registers one partial-sum row per request: bias lanes
// sign-extended to the accumulator width, obuf lanes passed straight through.
module obuf_bias_psum_mux #(
    parameter int ARRAY_N    = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int BIAS_WIDTH = 32,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          obuf_bias_sel,
    input  logic                          tile_start,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic                          rd_last,
    output logic                          bias_rd_req,
    output logic [ADDR_W-1:0]             bias_rd_addr,
    input  logic [ARRAY_N*BIAS_WIDTH-1:0] bias_rd_data,
    output logic                          obuf_rd_req,
    output logic [ADDR_W-1:0]             obuf_rd_addr,
    input  logic [ARRAY_N*ACC_WIDTH-1:0]  obuf_rd_data,
    output logic                          psum_valid,
    output logic [ARRAY_N*ACC_WIDTH-1:0]  psum_out,
    output logic                          psum_last,
    busy
);

    // Enough room for RD_LAT tags in the pipe plus one row in the output register.
    localparam int CNT_W = $clog2(RD_LAT + 2);

    // Source select: latched on tile_start, but a coincident request already sees the new value.
    logic sel_q;
    logic sel_d;
    logic eff_sel;

    // Tag pipeline; stage RD_LAT-1 lines up with the buffers' returned data.
    logic [RD_LAT-1:0] tag_valid_q;
    logic [RD_LAT-1:0] tag_valid_d;
    logic [RD_LAT-1:0] tag_sel_q;
    logic [RD_LAT-1:0] tag_sel_d;
    logic [RD_LAT-1:0] tag_last_q;
    logic [RD_LAT-1:0] tag_last_d;

    // Output register and outstanding-request counter.
    logic                         psum_valid_q;
    logic                         psum_valid_d;
    logic [ARRAY_N*ACC_WIDTH-1:0] psum_out_q;
    logic [ARRAY_N*ACC_WIDTH-1:0] psum_out_d;
    logic                         psum_last_q;
    logic                         psum_last_d;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             cnt_d;

    logic [ARRAY_N*ACC_WIDTH-1:0] bias_ext;
    logic                         cap_valid;
    logic                         cap_sel;
    logic                         cap_last;
    logic                         req_accept;

    assign eff_sel    = tile_start ? obuf_bias_sel : sel_q;
    assign sel_d      = eff_sel;
    assign req_accept = rd_req & ~reset;

    // Strobes are gated by reset so nothing reaches the buffers while the block is being cleared.
    assign bias_rd_req  = rd_req & ~eff_sel & ~reset;
    assign obuf_rd_req  = rd_req &  eff_sel & ~reset;
    assign bias_rd_addr = rd_addr;
    assign obuf_rd_addr = rd_addr;

    // Stage 0 samples the request every cycle; later stages shift the tag along unchanged.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_d[gi] = rd_req;
                assign tag_sel_d[gi]   = eff_sel;
                assign tag_last_d[gi]  = rd_last;
            end else begin : g_shift
                assign tag_valid_d[gi] = tag_valid_q[gi-1];
                assign tag_sel_d[gi]   = tag_sel_q[gi-1];
                assign tag_last_d[gi]  = tag_last_q[gi-1];
            end
        end
    endgenerate

    // Per-lane sign extension of the bias row into accumulator-width lanes.
    generate
        for (gi = 0; gi < ARRAY_N; gi++) begin : g_lane
            assign bias_ext[gi*ACC_WIDTH +: ACC_WIDTH] =
                ACC_WIDTH'($signed(bias_rd_data[gi*BIAS_WIDTH +: BIAS_WIDTH]));
        end
    endgenerate

    assign cap_valid = tag_valid_q[RD_LAT-1];
    assign cap_sel   = tag_sel_q[RD_LAT-1];
    assign cap_last  = tag_last_q[RD_LAT-1];

    // Output row: load on a returning tag, otherwise hold data/last and drop valid.
    always_comb begin
        psum_valid_d = cap_valid;
        psum_out_d   = psum_out_q;
        psum_last_d  = psum_last_q;
        if (cap_valid) begin
            psum_out_d  = cap_sel ? obuf_rd_data : bias_ext;
            psum_last_d = cap_last;
        end
    end

    // Outstanding count: up on an accepted request, down on each delivered row.
    always_comb begin
        cnt_d = cnt_q;
        case ({req_accept, psum_valid_q})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State update; reset discards every in-flight tag so no stale row is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= 1'b0;
            tag_valid_q  <= '0;
            tag_sel_q    <= '0;
            tag_last_q   <= '0;
            psum_valid_q <= 1'b0;
            psum_out_q   <= '0;
            psum_last_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sel_q        <= sel_d;
            tag_valid_q  <= tag_valid_d;
            tag_sel_q    <= tag_sel_d;
            tag_last_q   <= tag_last_d;
            psum_valid_q <= psum_valid_d;
            psum_out_q   <= psum_out_d;
            psum_last_q  <= psum_last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign psum_valid = psum_valid_q;
    assign psum_out   = psum_out_q;
    assign psum_last  = psum_last_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_obuf_bias_psum_mux.sv
// Bench for obuf_bias_psum_mux: table of routing vectors plus hand sequences,
// with a scoreboard queue of expected rows checked against every psum_valid.
module tb_obuf_bias_psum_mux;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int BW  = 16;
    localparam int ADW = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             obuf_bias_sel;
    logic             tile_start;
    logic             rd_req;
    logic [ADW-1:0]   rd_addr;
    logic             rd_last;
    logic             bias_rd_req;
    logic [ADW-1:0]   bias_rd_addr;
    logic [N*BW-1:0]  bias_rd_data;
    logic             obuf_rd_req;
    logic [ADW-1:0]   obuf_rd_addr;
    logic [N*AW-1:0]  obuf_rd_data;
    logic             psum_valid;
    logic [N*AW-1:0]  psum_out;
    logic             psum_last;
    logic             busy;

    obuf_bias_psum_mux #(
        .ARRAY_N(N), .ACC_WIDTH(AW), .BIAS_WIDTH(BW), .ADDR_W(ADW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .obuf_bias_sel(obuf_bias_sel), .tile_start(tile_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
        .bias_rd_req(bias_rd_req), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .obuf_rd_req(obuf_rd_req), .obuf_rd_addr(obuf_rd_addr), .obuf_rd_data(obuf_rd_data),
        .psum_valid(psum_valid), .psum_out(psum_out), .psum_last(psum_last), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pulses = 0;

    typedef struct {
        logic [N*AW-1:0] row;
        logic            last;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic           ts;
        logic           sel;
        logic           req;
        logic [ADW-1:0] a;
        logic           last;
        logic           exp_b;
        logic           exp_o;
    } vec_t;
    vec_t vt[19];

    logic           sel_m;
    logic           got_b, got_o;
    logic [ADW-1:0] got_ba, got_oa;

    // Buffer contents as functions of the row address.
    function automatic logic [BW-1:0] bias_lane(input logic [ADW-1:0] a, input int i);
        if (a == 16'd5) begin
            case (i)
                0: return 16'hFFFF;
                1: return 16'h0002;
                2: return 16'hFFFD;
                default: return 16'h0004;
            endcase
        end
        return BW'(32'(a) * 4099 + i * 40503);
    endfunction

    function automatic logic [AW-1:0] obuf_lane(input logic [ADW-1:0] a, input int i);
        return (32'(a) * 32'h01000193) ^ (32'(i) * 32'h9E3779B9) ^ 32'h00A5_0000;
    endfunction

    function automatic logic [N*AW-1:0] exp_row(input logic [ADW-1:0] a, input logic src);
        logic [N*AW-1:0] r;
        logic [BW-1:0]   b;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (src) begin
                r[i*AW +: AW] = obuf_lane(a, i);
            end else begin
                b = bias_lane(a, i);
                r[i*AW +: AW] = {{(AW-BW){b[BW-1]}}, b};
            end
        end
        return r;
    endfunction

    // Buffer models: data appears LAT cycles after the strobe address.
    logic [ADW-1:0] b_ap [LAT];
    logic [ADW-1:0] o_ap [LAT];
    always @(posedge clk) begin
        b_ap[0] <= bias_rd_addr;
        o_ap[0] <= obuf_rd_addr;
        for (int k = 1; k < LAT; k++) begin
            b_ap[k] <= b_ap[k-1];
            o_ap[k] <= o_ap[k-1];
        end
    end
    always_comb begin
        bias_rd_data = '0;
        obuf_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            bias_rd_data[i*BW +: BW] = bias_lane(b_ap[LAT-1], i);
            obuf_rd_data[i*AW +: AW] = obuf_lane(o_ap[LAT-1], i);
        end
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_v;
        if (reset) begin
            sb.delete();
        end else begin
            exp_busy = 1'b0;
            foreach (sb[j]) if (sb[j].cyc <= cyc + LAT) exp_busy = 1'b1;
            chk("busy", N*AW'(busy), N*AW'(exp_busy));
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            if (psum_valid) n_pulses++;
            if (psum_valid || exp_v) begin
                chk("psum_valid", N*AW'(psum_valid), N*AW'(exp_v));
                if (psum_valid && exp_v) begin
                    chk("psum_out", psum_out, sb[0].row);
                    chk("psum_last", N*AW'(psum_last), N*AW'(sb[0].last));
                    $display("cycle %0d psum row %h last %b", cyc, psum_out, psum_last);
                end
                if (exp_v) void'(sb.pop_front());
            end
        end
    end

    // One cycle of stimulus; records strobe outputs and queues the expected row.
    task automatic step(input logic rst, input logic ts, input logic sel, input logic req,
                        input logic [ADW-1:0] a, input logic last);
        logic eff;
        exp_t e;
        reset = rst; tile_start = ts; obuf_bias_sel = sel; rd_req = req; rd_addr = a; rd_last = last;
        eff = ts ? sel : sel_m;
        #1;
        got_b = bias_rd_req; got_o = obuf_rd_req; got_ba = bias_rd_addr; got_oa = obuf_rd_addr;
        if (rst) sel_m = 1'b0;
        else if (ts) sel_m = sel;
        if (req && !rst) begin
            e.row = exp_row(a, eff);
            e.last = last;
            e.cyc = cyc + LAT + 1;
            sb.push_back(e);
            $display("cycle %0d request addr %h src %s last %b", cyc, a, eff ? "obuf" : "bias", last);
        end
        @(posedge clk); #1;
        tile_start = 1'b0; rd_req = 1'b0; rd_last = 1'b0;
    endtask

    task automatic chk_strobes(input string nm, input logic eb, input logic eo, input logic [ADW-1:0] a);
        chk({nm, " bias_rd_req"}, N*AW'(got_b), N*AW'(eb));
        chk({nm, " obuf_rd_req"}, N*AW'(got_o), N*AW'(eo));
        chk({nm, " bias_rd_addr"}, N*AW'(got_ba), N*AW'(a));
        chk({nm, " obuf_rd_addr"}, N*AW'(got_oa), N*AW'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset = 1'b1; obuf_bias_sel = 1'b0; tile_start = 1'b0; rd_req = 1'b0;
        rd_addr = '0; rd_last = 1'b0; sel_m = 1'b0;

        vt[0]  = '{1'b1, 1'b1, 1'b1, 16'd0,    1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 16'd1,    1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 16'd2,    1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 16'd3,    1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 16'd7,    1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 16'd8,    1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 16'd21,   1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b1, 16'd9,    1'b0, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        vt[16] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;

        // Requests during reset must not strobe either buffer.
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0);
        chk_strobes("in_reset bias", 1'b0, 1'b0, 16'h0011);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0012, 1'b0);
        chk_strobes("in_reset obuf", 1'b0, 1'b0, 16'h0012);
        chk("reset psum_valid", N*AW'(psum_valid), '0);
        chk("reset psum_out", psum_out, '0);
        chk("reset psum_last", N*AW'(psum_last), '0);
        chk("reset busy", N*AW'(busy), '0);

        // Bias path: sign extension of {-1,2,-3,4}, row appears three cycles after the request.
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
        chk_strobes("bias_path", 1'b1, 1'b0, 16'd5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        chk("bias_path early valid", N*AW'(psum_valid), '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        chk("bias_path valid", N*AW'(psum_valid), N*AW'(1'b1));
        chk("bias_path lanes", psum_out, 128'h00000004_FFFFFFFD_00000002_FFFFFFFF);

        // Routing table: obuf burst, bias tile, coincident switch, idle tile_start latch.
        for (int i = 0; i < 19; i++) begin
            step(1'b0, vt[i].ts, vt[i].sel, vt[i].req, vt[i].a, vt[i].last);
            chk_strobes($sformatf("vec%0d", i), vt[i].exp_b, vt[i].exp_o, vt[i].a);
        end

        // Counter bound: ten back-to-back obuf requests.
        p0 = n_pulses;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 0), 1'b1, 1'b1, 16'(100 + i), (i == 9));
            chk($sformatf("burst%0d obuf_rd_req", i), N*AW'(got_o), N*AW'(1'b1));
            chk($sformatf("burst%0d busy", i), N*AW'(busy), N*AW'(1'b1));
            if (i >= 2) chk($sformatf("burst%0d count", i), N*AW'(dut.cnt_q), N*AW'(3));
        end
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        chk("burst pulse count", N*AW'(n_pulses - p0), N*AW'(10));
        chk("burst drained busy", N*AW'(busy), '0);

        // Reset mid-operation: in-flight rows are dropped, latched select returns to bias.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd40, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd41, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'd42, 1'b0);
        chk_strobes("reset_mid", 1'b0, 1'b0, 16'd42);
        chk("post_reset psum_valid", N*AW'(psum_valid), '0);
        chk("post_reset psum_out", psum_out, '0);
        chk("post_reset psum_last", N*AW'(psum_last), '0);
        chk("post_reset busy", N*AW'(busy), '0);
        p0 = n_pulses;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        chk("post_reset no pulses", N*AW'(n_pulses - p0), '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'd50, 1'b1);
        chk_strobes("post_reset sel", 1'b1, 1'b0, 16'd50);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
